// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing the RAM data port between m0 (core LSU) and m1 (DMA/debug).
// Optional per-master grant counters are enabled by defining ARB_PERF_CNT_EN.
module data_bus_arbiter #(
    parameter int RAM_SIZE = 256,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_require,
    input  logic              m0_write_enable,
    input  logic [3:0]        m0_byte_enable_map,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [31:0]       m0_write,
    output logic [31:0]       m0_read,
    output logic              m0_ready,
    output logic              m0_fault,
    input  logic              m1_require,
    input  logic              m1_write_enable,
    input  logic [3:0]        m1_byte_enable_map,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [31:0]       m1_write,
    output logic [31:0]       m1_read,
    output logic              m1_ready,
    output logic              m1_fault,
`ifdef ARB_PERF_CNT_EN
    output logic [15:0]       m0_grant_count,
    output logic [15:0]       m1_grant_count,
`endif
    output logic              ram_require,
    output logic              ram_write_enable,
    output logic [3:0]        ram_byte_enable_map,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_write,
    input  logic [31:0]       ram_read
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [3:0]        bem_q, bem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              fault_q, fault_d;

    logic              any_req;
    logic              sel;
    logic [ADDR_W-1:0] sel_addr;

    assign any_req  = m0_require | m1_require;
    // A tie goes to whichever master was not served last.
    assign sel      = (m0_require && m1_require) ? ~last_grant_q : m1_require;
    assign sel_addr = sel ? m1_address : m0_address;

    // NOTE: every signal assigned here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        bem_d        = bem_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        fault_d      = fault_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    we_d         = sel ? m1_write_enable    : m0_write_enable;
                    bem_d        = sel ? m1_byte_enable_map : m0_byte_enable_map;
                    addr_d       = sel_addr;
                    wdata_d      = sel ? m1_write           : m0_write;
                    fault_d      = !(sel_addr < ADDR_W'(RAM_SIZE));
                    state_d      = fault_d ? RESPOND : ACCESS;
                end
            end
            ACCESS:  state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            bem_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            bem_q        <= bem_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            fault_q      <= fault_d;
        end
    end

    // RAM port is decoded from the state flop, so an async reset drops it immediately.
    logic in_access;
    assign in_access           = (state_q == ACCESS);
    assign ram_require         = in_access;
    assign ram_write_enable    = in_access & we_q;
    assign ram_byte_enable_map = in_access ? bem_q   : '0;
    assign ram_address         = in_access ? addr_q  : '0;
    assign ram_write           = in_access ? wdata_q : '0;

    // The RAM's registered read port holds the load data during RESPOND.
    logic        in_respond;
    logic [31:0] load_data;
    assign in_respond = (state_q == RESPOND);
    assign load_data  = (!we_q && !fault_q) ? ram_read : '0;
    assign m0_ready   = in_respond & ~grant_q;
    assign m1_ready   = in_respond &  grant_q;
    assign m0_fault   = m0_ready & fault_q;
    assign m1_fault   = m1_ready & fault_q;
    assign m0_read    = m0_ready ? load_data : '0;
    assign m1_read    = m1_ready ? load_data : '0;

`ifdef ARB_PERF_CNT_EN
    logic        grant_fire;
    logic [15:0] m0_grant_count_q, m0_grant_count_d;
    logic [15:0] m1_grant_count_q, m1_grant_count_d;

    assign grant_fire = (state_q == IDLE) && any_req;

    always_comb begin
        m0_grant_count_d = m0_grant_count_q;
        m1_grant_count_d = m1_grant_count_q;
        if (grant_fire && !sel && (m0_grant_count_q != 16'hFFFF))
            m0_grant_count_d = m0_grant_count_q + 16'd1;
        if (grant_fire && sel && (m1_grant_count_q != 16'hFFFF))
            m1_grant_count_d = m1_grant_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_grant_count_q <= '0;
            m1_grant_count_q <= '0;
        end else begin
            m0_grant_count_q <= m0_grant_count_d;
            m1_grant_count_q <= m1_grant_count_d;
        end
    end

    assign m0_grant_count = m0_grant_count_q;
    assign m1_grant_count = m1_grant_count_q;
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed self-checking bench for data_bus_arbiter with a small synchronous RAM model.
// Define ARB_PERF_CNT_EN for both files to exercise the grant counters.
module tb_data_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_require = 1'b0, m0_write_enable = 1'b0;
    logic [3:0]  m0_byte_enable_map = '0;
    logic [31:0] m0_address = '0, m0_write = '0;
    logic [31:0] m0_read;
    logic        m0_ready, m0_fault;
    logic        m1_require = 1'b0, m1_write_enable = 1'b0;
    logic [3:0]  m1_byte_enable_map = '0;
    logic [31:0] m1_address = '0, m1_write = '0;
    logic [31:0] m1_read;
    logic        m1_ready, m1_fault;
    logic        ram_require, ram_write_enable;
    logic [3:0]  ram_byte_enable_map;
    logic [31:0] ram_address, ram_write;
    logic [31:0] ram_read;
`ifdef ARB_PERF_CNT_EN
    logic [15:0] m0_grant_count, m1_grant_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] last_read;
    logic [3:0]  last_ram_bem;
    logic [31:0] last_ram_wdata;

    always #5 clk = ~clk;

    data_bus_arbiter #(.RAM_SIZE(256), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_require(m0_require), .m0_write_enable(m0_write_enable),
        .m0_byte_enable_map(m0_byte_enable_map), .m0_address(m0_address),
        .m0_write(m0_write), .m0_read(m0_read), .m0_ready(m0_ready), .m0_fault(m0_fault),
        .m1_require(m1_require), .m1_write_enable(m1_write_enable),
        .m1_byte_enable_map(m1_byte_enable_map), .m1_address(m1_address),
        .m1_write(m1_write), .m1_read(m1_read), .m1_ready(m1_ready), .m1_fault(m1_fault),
`ifdef ARB_PERF_CNT_EN
        .m0_grant_count(m0_grant_count), .m1_grant_count(m1_grant_count),
`endif
        .ram_require(ram_require), .ram_write_enable(ram_write_enable),
        .ram_byte_enable_map(ram_byte_enable_map), .ram_address(ram_address),
        .ram_write(ram_write), .ram_read(ram_read)
    );

    // RAM model: 64 words, registered read, byte-lane writes, known contents after reset.
    logic [31:0] mem [0:63];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
            mem[4]   <= 32'hDEAD_BEEF;
            mem[5]   <= 32'h1234_5678;
            mem[8]   <= 32'h1122_3344;
            ram_read <= '0;
        end else if (ram_require) begin
            if (ram_write_enable)
                for (int b = 0; b < 4; b++)
                    if (ram_byte_enable_map[b]) mem[ram_address[7:2]][8*b +: 8] <= ram_write[8*b +: 8];
            ram_read <= mem[ram_address[7:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m0_require = 1'b0;
        m1_require = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive(input bit m, input bit req, input bit we, input logic [3:0] bem,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (m) begin
            m1_require = req; m1_write_enable = we; m1_byte_enable_map = bem;
            m1_address = addr; m1_write = wd;
        end else begin
            m0_require = req; m0_write_enable = we; m0_byte_enable_map = bem;
            m0_address = addr; m0_write = wd;
        end
    endtask

    // Issues one access from an idle arbiter and checks latency, response and RAM activity.
    task automatic do_access(input string tag, input bit m, input bit we, input logic [3:0] bem,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int exp_lat, input bit exp_fault, input logic [31:0] exp_rd);
        int lat = 0;
        bit got = 0;
        bit saw_ram = 0;
        bit other_rdy = 0;
        logic        flt = 1'b0;
        logic [31:0] rd = '0;
        @(negedge clk);
        drive(m, 1'b1, we, bem, addr, wd);
        while (!got && lat < 6) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (ram_require) begin
                saw_ram = 1;
                last_ram_bem = ram_byte_enable_map;
                last_ram_wdata = ram_write;
            end
            if (m ? m0_ready : m1_ready) other_rdy = 1;
            if (m ? m1_ready : m0_ready) begin
                got = 1;
                flt = m ? m1_fault : m0_fault;
                rd  = m ? m1_read : m0_read;
            end
        end
        drive(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        last_read = rd;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_fault"}, {31'd0, flt}, {31'd0, exp_fault});
        check({tag, "_read"}, rd, exp_rd);
        check({tag, "_ram_req_seen"}, {31'd0, saw_ram}, {31'd0, !exp_fault});
        check({tag, "_other_ready"}, {31'd0, other_rdy}, 32'd0);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int who;
        int waited;

        // Reset state: every output low.
        #2;
        check("rst_ram_require", {31'd0, ram_require}, 32'd0);
        check("rst_ram_address", ram_address, 32'd0);
        check("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        check("rst_fault", {30'd0, m1_fault, m0_fault}, 32'd0);
        check("rst_m0_read", m0_read, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single m0 load, stepped cycle by cycle.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        @(posedge clk); @(negedge clk);
        check("ld_access_req", {31'd0, ram_require}, 32'd1);
        check("ld_access_addr", ram_address, 32'h10);
        check("ld_access_we", {31'd0, ram_write_enable}, 32'd0);
        check("ld_access_ready", {31'd0, m0_ready}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("ld_resp_req", {31'd0, ram_require}, 32'd0);
        check("ld_resp_ready", {31'd0, m0_ready}, 32'd1);
        check("ld_resp_read", m0_read, 32'hDEAD_BEEF);
        check("ld_resp_fault", {31'd0, m0_fault}, 32'd0);
        check("ld_resp_m1_ready", {31'd0, m1_ready}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); @(negedge clk);
        check("ld_idle_ready", {31'd0, m0_ready}, 32'd0);

        // Tie after reset: both held, grants alternate starting with m0.
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        for (int k = 0; k < 4; k++) begin
            who = 2;
            waited = 0;
            while (who == 2 && waited < 5) begin
                @(posedge clk); @(negedge clk);
                waited++;
                if (m0_ready) who = 0;
                else if (m1_ready) who = 1;
            end
            check($sformatf("tie_grant%0d", k), who, k % 2);
            check($sformatf("tie_read%0d", k), (who == 1) ? m1_read : m0_read,
                  (k % 2) ? 32'h1234_5678 : 32'hDEAD_BEEF);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); @(posedge clk);

        // Range boundaries.
        do_access("m1_oor_store", 1'b1, 1'b1, 4'hF, 32'h100, 32'hCAFE_F00D, 1, 1'b1, 32'h0);
        do_access("m0_last_word", 1'b0, 1'b0, 4'h0, 32'hFC, 32'h0, 2, 1'b0, 32'hA500_003F);
        do_access("m0_high_bit", 1'b0, 1'b0, 4'h0, 32'h8000_0010, 32'h0, 1, 1'b1, 32'h0);

        // Byte-lane store, then read-back.
        do_access("m1_byte_store", 1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000_AB00, 2, 1'b0, 32'h0);
        check("byte_store_ram_bem", {28'd0, last_ram_bem}, 32'h2);
        check("byte_store_ram_wdata", last_ram_wdata, 32'h0000_AB00);
        do_access("m0_byte_load", 1'b0, 1'b0, 4'h0, 32'h20, 32'h0, 2, 1'b0, 32'h1122_AB44);
        check("byte_load_byte1", {24'd0, last_read[15:8]}, 32'hAB);

        // Reset during ACCESS aborts without a ready pulse.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        @(posedge clk); @(negedge clk);
        check("mid_rst_in_access", {31'd0, ram_require}, 32'd1);
        #1 reset = 1'b1;
        m0_require = 1'b0;
        #1;
        check("mid_rst_req_drop", {31'd0, ram_require}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("mid_rst_no_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        check("post_rst_no_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        do_access("m1_after_rst", 1'b1, 1'b0, 4'h0, 32'h14, 32'h0, 2, 1'b0, 32'h1234_5678);

        // Three m0 grants (one a fault) after the single m1 grant above.
        do_access("m0_cnt_ld", 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);
        do_access("m0_cnt_fault", 1'b0, 1'b0, 4'h0, 32'h200, 32'h0, 1, 1'b1, 32'h0);
        do_access("m0_cnt_st", 1'b0, 1'b1, 4'hF, 32'h24, 32'h0BAD_CAFE, 2, 1'b0, 32'h0);
`ifdef ARB_PERF_CNT_EN
        check("cnt_m0", {16'd0, m0_grant_count}, 32'd3);
        check("cnt_m1", {16'd0, m1_grant_count}, 32'd1);
        @(negedge clk);
        force dut.m0_grant_count_q = 16'hFFFF;
        #1 release dut.m0_grant_count_q;
        do_access("m0_cnt_sat_ld", 1'b0, 1'b0, 4'h0, 32'h24, 32'h0, 2, 1'b0, 32'h0BAD_CAFE);
        check("cnt_m0_saturated", {16'd0, m0_grant_count}, 32'hFFFF);
        check("cnt_m1_unchanged", {16'd0, m1_grant_count}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
